// File: rtl/as_pack.sv
// Shared TAP definitions: state encodings, IR geometry and opcode values.
package as_pack;

    localparam int ir_width = 4;

    localparam logic [3:0] ir_capture = 4'b0001;

    localparam logic [3:0] op_extest = 4'h0;
    localparam logic [3:0] op_sample = 4'h2;
    localparam logic [3:0] op_dr1    = 4'h8;
    localparam logic [3:0] op_bypass = 4'hF;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // True for the two states in which a serial shift drives TDO.
    function automatic logic is_shift_state(input tap_state_t st);
        return (st == SH_DR) || (st == SH_IR);
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// TMS-driven 16-state TAP state machine with debug state and TLR flag.
module tap_fsm
    import as_pack::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       tlr_o
);

    tap_state_t state_r;
    tap_state_t state_nxt_s;

    // State register; reset forces TEST_LOGIC_RESET immediately.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_r <= TLR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode from the current state and TMS.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            TLR:     state_nxt_s = tms_i ? TLR    : RTI;
            RTI:     state_nxt_s = tms_i ? SEL_DR : RTI;
            SEL_DR:  state_nxt_s = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt_s = tms_i ? EX1_DR : SH_DR;
            SH_DR:   state_nxt_s = tms_i ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt_s = tms_i ? UPD_DR : PA_DR;
            PA_DR:   state_nxt_s = tms_i ? EX2_DR : PA_DR;
            EX2_DR:  state_nxt_s = tms_i ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt_s = tms_i ? SEL_DR : RTI;
            SEL_IR:  state_nxt_s = tms_i ? TLR    : CAP_IR;
            CAP_IR:  state_nxt_s = tms_i ? EX1_IR : SH_IR;
            SH_IR:   state_nxt_s = tms_i ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt_s = tms_i ? UPD_IR : PA_IR;
            PA_IR:   state_nxt_s = tms_i ? EX2_IR : PA_IR;
            EX2_IR:  state_nxt_s = tms_i ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt_s = tms_i ? SEL_DR : RTI;
            default: state_nxt_s = TLR;
        endcase
    end

    assign state_o = state_r;
    assign tlr_o   = (state_r == TLR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: FSM, instruction register, decode, BYPASS and TDO mux.
module jtag_tap_ctrl #(
    parameter int                  ir_width   = as_pack::ir_width,
    parameter logic [ir_width-1:0] ir_capture = as_pack::ir_capture
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms_i,
    input  logic       tdi_i,
    output logic       tdo_o,
    output logic       tdo_en_o,
    output logic [3:0] state_o,
    output logic       tlr_o,
    output logic       mode_o,
    output logic       dr_shift_o,
    output logic       dr1_clock_o,
    output logic       dr1_upd_o,
    output logic       bsr_clock_o,
    output logic       bsr_upd_o,
    input  logic       dr1_sero_i,
    input  logic       bsr_sero_i
);

    import as_pack::*;

    localparam logic [ir_width-1:0] bypass_code_c = ir_width'(op_bypass);

    tap_state_t          state_s;
    logic                tlr_s;
    logic [ir_width-1:0] ir_shift_r;
    logic [ir_width-1:0] ir_hold_r;
    logic                bypass_r;
    logic                tdo_r;
    logic                tdo_en_r;
    logic                sel_dr1_s;
    logic                sel_bsr_s;
    logic                sel_byp_s;
    logic                mode_s;
    logic                tdo_mux_s;
    logic                cap_or_shift_dr_s;

    tap_fsm u_fsm (
        .tck     (tck),
        .trst    (trst),
        .tms_i   (tms_i),
        .state_o (state_s),
        .tlr_o   (tlr_s)
    );

    // IR shift stage: capture constant, then shift right with TDI into the MSB.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_shift_r <= ir_capture;
        end else if (state_s == CAP_IR) begin
            ir_shift_r <= ir_capture;
        end else if (state_s == SH_IR) begin
            ir_shift_r <= {tdi_i, ir_shift_r[ir_width-1:1]};
        end else begin
            ir_shift_r <= ir_shift_r;
        end
    end

    // IR hold register: BYPASS in TLR, otherwise updated from the shift stage.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_hold_r <= bypass_code_c;
        end else if (state_s == TLR) begin
            ir_hold_r <= bypass_code_c;
        end else if (state_s == UPD_IR) begin
            ir_hold_r <= ir_shift_r;
        end else begin
            ir_hold_r <= ir_hold_r;
        end
    end

    // Instruction decode; unknown opcodes fall back to BYPASS.
    always_comb begin
        sel_dr1_s = 1'b0;
        sel_bsr_s = 1'b0;
        mode_s    = 1'b0;
        case (ir_hold_r)
            ir_width'(op_extest): begin
                sel_bsr_s = 1'b1;
                mode_s    = 1'b1;
            end
            ir_width'(op_sample): begin
                sel_bsr_s = 1'b1;
                mode_s    = 1'b0;
            end
            ir_width'(op_dr1): begin
                sel_dr1_s = 1'b1;
                mode_s    = 1'b1;
            end
            default: begin
                sel_dr1_s = 1'b0;
                sel_bsr_s = 1'b0;
                mode_s    = 1'b0;
            end
        endcase
    end

    assign sel_byp_s = ~sel_dr1_s & ~sel_bsr_s;

    // BYPASS flop: cleared on capture, follows TDI while shifting when selected.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass_r <= 1'b0;
        end else if (state_s == CAP_DR) begin
            bypass_r <= 1'b0;
        end else if ((state_s == SH_DR) && sel_byp_s) begin
            bypass_r <= tdi_i;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // TDO source selection by state and selected register.
    always_comb begin
        tdo_mux_s = 1'b0;
        case (state_s)
            SH_IR: tdo_mux_s = ir_shift_r[0];
            SH_DR: begin
                if (sel_dr1_s) begin
                    tdo_mux_s = dr1_sero_i;
                end else if (sel_bsr_s) begin
                    tdo_mux_s = bsr_sero_i;
                end else begin
                    tdo_mux_s = bypass_r;
                end
            end
            default: tdo_mux_s = 1'b0;
        endcase
    end

    // TDO and its enable launch on the falling edge, half a cycle after the mux.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_r    <= 1'b0;
            tdo_en_r <= 1'b0;
        end else begin
            tdo_r    <= tdo_mux_s;
            tdo_en_r <= is_shift_state(state_s);
        end
    end

    assign cap_or_shift_dr_s = (state_s == CAP_DR) || (state_s == SH_DR);

    assign state_o     = state_s;
    assign tlr_o       = tlr_s;
    assign mode_o      = mode_s;
    assign dr_shift_o  = (state_s == SH_DR);
    assign dr1_clock_o = cap_or_shift_dr_s & sel_dr1_s;
    assign dr1_upd_o   = (state_s == UPD_DR) & sel_dr1_s;
    assign bsr_clock_o = cap_or_shift_dr_s & sel_bsr_s;
    assign bsr_upd_o   = (state_s == UPD_DR) & sel_bsr_s;
    assign tdo_o       = tdo_r;
    assign tdo_en_o    = tdo_en_r;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: a driver pushes expected outputs from a
// table-driven TAP model, a monitor pops and compares once per cycle.
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst = 1'b0;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       d1_sero = 1'b0;
    logic       b_sero = 1'b0;
    logic       tdo, tdo_en, tlr, mode, dr_shift;
    logic       dr1_clock, dr1_upd, bsr_clock, bsr_upd;
    logic [3:0] state;

    jtag_tap_ctrl dut (
        .tck         (tck),
        .trst        (trst),
        .tms_i       (tms),
        .tdi_i       (tdi),
        .tdo_o       (tdo),
        .tdo_en_o    (tdo_en),
        .state_o     (state),
        .tlr_o       (tlr),
        .mode_o      (mode),
        .dr_shift_o  (dr_shift),
        .dr1_clock_o (dr1_clock),
        .dr1_upd_o   (dr1_upd),
        .bsr_clock_o (bsr_clock),
        .bsr_upd_o   (bsr_upd),
        .dr1_sero_i  (d1_sero),
        .bsr_sero_i  (b_sero)
    );

    always #5 tck = ~tck;

    typedef struct {
        int st;
        bit tlr, mode, dsh, d1c, d1u, bc, bu, tdo, tdoe;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: state as spec hex code, IR and bypass as plain integers.
    int m_state = 15;
    int m_irs   = 1;
    int m_irh   = 15;
    bit m_byp   = 1'b0;

    function automatic int next_state(input int s, input bit t);
        case (s)
            15: return t ? 15 : 12;
            12: return t ? 7  : 12;
            7:  return t ? 4  : 6;
            6:  return t ? 1  : 2;
            2:  return t ? 1  : 2;
            1:  return t ? 5  : 3;
            3:  return t ? 0  : 3;
            0:  return t ? 5  : 2;
            5:  return t ? 7  : 12;
            4:  return t ? 15 : 14;
            14: return t ? 9  : 10;
            10: return t ? 9  : 10;
            9:  return t ? 13 : 11;
            11: return t ? 8  : 11;
            8:  return t ? 13 : 10;
            13: return t ? 7  : 12;
            default: return 15;
        endcase
    endfunction

    function automatic void decode(input int op, output bit sd1, output bit sb, output bit md);
        sd1 = 1'b0; sb = 1'b0; md = 1'b0;
        if (op == 0) begin sb = 1'b1; md = 1'b1; end
        else if (op == 2) begin sb = 1'b1; end
        else if (op == 8) begin sd1 = 1'b1; md = 1'b1; end
    endfunction

    function automatic void model_reset();
        m_state = 15; m_irs = 1; m_irh = 15; m_byp = 1'b0;
    endfunction

    function automatic void model_clock(input bit t, input bit di);
        bit sd1, sb, md;
        int s, irs_old;
        s = m_state;
        irs_old = m_irs;
        decode(m_irh, sd1, sb, md);
        if (s == 14) m_irs = 1;
        else if (s == 10) m_irs = (irs_old >> 1) | (int'(di) << 3);
        if (s == 15) m_irh = 15;
        else if (s == 13) m_irh = irs_old;
        if (s == 6) m_byp = 1'b0;
        else if (s == 2 && !sd1 && !sb) m_byp = di;
        m_state = next_state(s, t);
    endfunction

    function automatic void push_expected();
        exp_t e;
        bit sd1, sb, md;
        int s;
        s = m_state;
        decode(m_irh, sd1, sb, md);
        e.st   = s;
        e.tlr  = (s == 15);
        e.mode = md;
        e.dsh  = (s == 2);
        e.d1c  = (s == 6 || s == 2) && sd1;
        e.d1u  = (s == 5) && sd1;
        e.bc   = (s == 6 || s == 2) && sb;
        e.bu   = (s == 5) && sb;
        e.tdoe = (s == 10 || s == 2);
        if (s == 10) e.tdo = m_irs[0];
        else if (s == 2) e.tdo = sd1 ? d1_sero : (sb ? b_sero : m_byp);
        else e.tdo = 1'b0;
        if (!trst) begin
            e.tdo  = 1'b0;
            e.tdoe = 1'b0;
        end
        sb_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endfunction

    // Monitor: after each falling edge the DUT presents one cycle of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge tck);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("state",     int'(state),     e.st);
                chk("tlr",       int'(tlr),       int'(e.tlr));
                chk("mode",      int'(mode),      int'(e.mode));
                chk("dr_shift",  int'(dr_shift),  int'(e.dsh));
                chk("dr1_clock", int'(dr1_clock), int'(e.d1c));
                chk("dr1_upd",   int'(dr1_upd),   int'(e.d1u));
                chk("bsr_clock", int'(bsr_clock), int'(e.bc));
                chk("bsr_upd",   int'(bsr_upd),   int'(e.bu));
                chk("tdo",       int'(tdo),       int'(e.tdo));
                chk("tdo_en",    int'(tdo_en),    int'(e.tdoe));
            end
        end
    end

    // One TCK cycle: drive inputs, record expectation, advance the model.
    task automatic step(input bit t, input bit di, input bit a, input bit b);
        tms = t; tdi = di; d1_sero = a; b_sero = b;
        push_expected();
        @(posedge tck);
        if (trst) model_clock(t, di);
        #2;
    endtask

    task automatic reset_pulse(input int n);
        trst = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        trst = 1'b1;
    endtask

    task automatic ir_scan(input int op, input bit from_tlr);
        if (from_tlr) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(i == 3, op[i], 1'($urandom), 1'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n, input int tdi_pat, input int sero_pat, input int abort_after);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == abort_after) begin
                reset_pulse(2);
                return;
            end
            step(i == n - 1, tdi_pat[i], sero_pat[i], ~sero_pat[i]);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Driver: directed scenarios followed by randomized TMS/TDI traffic.
    initial begin
        int waited;
        @(posedge tck);
        #2;
        reset_pulse(3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        ir_scan(8, 1'b1);
        dr_scan(8, int'($urandom_range(0, 255)), 32'hAD, -1);
        ir_scan(15, 1'b0);
        dr_scan(4, 32'b1101, int'($urandom_range(0, 15)), -1);
        ir_scan(5, 1'b0);
        dr_scan(6, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), -1);
        ir_scan(0, 1'b0);
        dr_scan(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
        ir_scan(2, 1'b0);
        dr_scan(5, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), -1);
        ir_scan(8, 1'b0);
        dr_scan(8, int'($urandom_range(0, 255)), 32'hAD, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        dr_scan(3, 32'b101, 32'b010, -1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset_pulse(1);
            end else begin
                step($urandom_range(0, 99) < 35, 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(negedge tck);
            #2;
            waited++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
